scpad_be_tile_loader: RTL and testbench
=======================================

Name: scpad_be_tile_loader

Overview:
Backend load sequencer for the scratchpad. It accepts one tile descriptor from the scheduler and breaks each tile row into DRAM bus-width read beats with per-beat element masks. Returned beats may arrive out of order; they are reassembled into a full scratchpad row and written to the selected scratchpad bank as one row write with a column valid mask. Compared with the fixed-geometry backend, this block adds:
- parametrised bus, row and ID widths;
- a DRAM row stride;
- multi-scratchpad steering;
- out-of-order response reassembly.

Parameters:
NUM_COLS, 32, elements per scratchpad row
ELEM_BITS, 16, bits per element
BUS_BITS, 64, DRAM data bus width; multiple of ELEM_BITS; divides NUM_COLS*ELEM_BITS
DRAM_ADDR_WIDTH, 32, DRAM byte address width
DRAM_ID_WIDTH, 4, DRAM transaction ID width; must be >= log2(BEATS)
SCPAD_ADDR_WIDTH, 16, scratchpad byte address width
NUM_SCPADS, 2, number of scratchpad banks
Derived: EPB=BUS_BITS/ELEM_BITS; BEATS=NUM_COLS/EPB; ROW_BYTES=NUM_COLS*ELEM_BITS/8; BUS_BYTES=BUS_BITS/8; DIMW=clog2(NUM_COLS); SIDW=max(1,clog2(NUM_SCPADS))

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
req_valid  in  1  tile descriptor valid
req_ready  out  1  high only in IDLE
req_spad_addr  in  SCPAD_ADDR_WIDTH  scratchpad base byte address, row aligned
req_dram_addr  in  DRAM_ADDR_WIDTH  DRAM base byte address, BUS_BYTES aligned
req_dram_stride  in  DRAM_ADDR_WIDTH  DRAM byte distance between consecutive rows
req_num_rows  in  DIMW  row count minus one
req_num_cols  in  DIMW  column count minus one
req_scpad_id  in  SIDW  target scratchpad bank
dram_req_valid  out  1  read beat request valid
dram_req_ready  in  1  DRAM controller accepts the beat
dram_req_addr  out  DRAM_ADDR_WIDTH  beat byte address
dram_req_id  out  DRAM_ID_WIDTH  beat index within the current row
dram_req_mask  out  EPB  element-enable mask for the beat
dram_res_valid  in  1  read data valid; always accepted
dram_res_id  in  DRAM_ID_WIDTH  ID of the returning beat
dram_res_rdata  in  BUS_BITS  returned beat data
sram_wr_valid  out  1  row write valid
sram_wr_ready  in  1  scratchpad accepts the row write
sram_wr_addr  out  SCPAD_ADDR_WIDTH  row byte address
sram_wr_data  out  NUM_COLS*ELEM_BITS  row data; element 0 occupies the LSBs
sram_wr_mask  out  NUM_COLS  column valid mask
sram_wr_scpad_id  out  SIDW  target scratchpad bank
done  out  1  one-cycle pulse when the tile completes
err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (async, nRST=0): state=IDLE; all counters, the row buffer and the received bitmap cleared. Outputs: req_ready=1, dram_req_valid=0, sram_wr_valid=0, done=0, err=0; all data outputs 0. Reset mid-tile abandons the tile; late DRAM responses after reset are treated as unexpected (see err).
- Descriptor capture: on req_valid&&req_ready, latch all fields. Row counter r=0, beat counter b=0. Number of needed beats NB = req_num_cols/EPB + 1. Go to ISSUE.
- ISSUE: dram_req_valid=1 with
  - addr = row_base + b*BUS_BYTES, where row_base = dram_addr + r*stride (mod 2^DRAM_ADDR_WIDTH);
  - id = b;
  - mask bit k set iff b*EPB+k <= num_cols.
  Valid and payload stay stable until ready. On handshake, b++. After beat NB-1 is accepted, go to WAIT. Responses may arrive during ISSUE.
- Response handling (any state): on dram_res_valid, if id<NB and its received bit is clear, write the beat into buffer elements [id*EPB +: EPB] and set the received bit. Otherwise (id>=NB, duplicate ID, or state IDLE/FLUSH) set err and drop the data.
- WAIT: when all NB received bits are set (including the bit set in the current cycle), go to FLUSH on the next cycle.
- FLUSH: sram_wr_valid=1 with
  - addr = spad_addr + r*ROW_BYTES (mod 2^SCPAD_ADDR_WIDTH);
  - data = buffer, with elements > num_cols forced to 0;
  - mask bit c set iff c <= num_cols;
  - scpad_id latched.
  On handshake, clear bitmap and buffer. If r==num_rows: done=1 for that cycle, go to IDLE. Otherwise r++, b=0, go to ISSUE.
- Latency: minimum 1 cycle per beat issue. Once the last beat arrives, FLUSH asserts 1 cycle later. done is asserted in the same cycle as the final sram write handshake.
- Only one row is in flight at a time, so IDs never alias across rows.
- num_cols=NUM_COLS-1 with EPB divisor gives NB=BEATS and all masks all-ones. num_rows=0 gives a single row.

Test Plan:
- Full tile: rows=1 (code 0), cols=31, dram_addr=0x1000, spad_addr=0x0040, in-order responses → 8 beats at 0x1000..0x1038 step 8, IDs 0..7, masks 4'hF; one sram write at addr 0x0040 with mask all-ones; done pulse.
- Partial row: cols code 9 → NB=3; beat masks F, F, 3; sram mask 0x3FF; elements 10..31 are 0.
- Stride and wrap: rows code 2, stride 0x200, spad_addr=0xFFC0 (SCPAD_ADDR_WIDTH=16, ROW_BYTES=64) → DRAM row bases 0x1000, 0x1200, 0x1400; sram addrs 0xFFC0, 0x0000, 0x0040.
- Out of order with backpressure: responses in ID order 7,0,3,…; dram_req_ready toggling; sram_wr_ready held low for 5 cycles → data correctly placed; payloads stable under stall; exactly one write.
- Errors: duplicate ID 2, and ID 9 when NB=8 → err=1 and stays 1; buffer contents unchanged by the dropped beats.
- Reset in WAIT after 4 beats → outputs return to reset values; a later response sets err=0→1 only after reset is released; the next tile completes normally.

Source files
------------

// File: rtl/scpad_be_tile_loader.sv
// Scratchpad backend tile loader: splits tile rows into DRAM read beats,
// reassembles out-of-order responses and writes whole rows to a scratchpad bank.
module scpad_be_tile_loader #(
    parameter int NUM_COLS         = 32,
    parameter int ELEM_BITS        = 16,
    parameter int BUS_BITS         = 64,
    parameter int DRAM_ADDR_WIDTH  = 32,
    parameter int DRAM_ID_WIDTH    = 4,
    parameter int SCPAD_ADDR_WIDTH = 16,
    parameter int NUM_SCPADS       = 2,
    localparam int EPB  = BUS_BITS / ELEM_BITS,
    localparam int DIMW = $clog2(NUM_COLS),
    localparam int SIDW = (NUM_SCPADS > 1) ? $clog2(NUM_SCPADS) : 1
) (
    input  logic                            CLK,
    input  logic                            nRST,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [SCPAD_ADDR_WIDTH-1:0]     req_spad_addr,
    input  logic [DRAM_ADDR_WIDTH-1:0]      req_dram_addr,
    input  logic [DRAM_ADDR_WIDTH-1:0]      req_dram_stride,
    input  logic [DIMW-1:0]                 req_num_rows,
    input  logic [DIMW-1:0]                 req_num_cols,
    input  logic [SIDW-1:0]                 req_scpad_id,
    output logic                            dram_req_valid,
    input  logic                            dram_req_ready,
    output logic [DRAM_ADDR_WIDTH-1:0]      dram_req_addr,
    output logic [DRAM_ID_WIDTH-1:0]        dram_req_id,
    output logic [EPB-1:0]                  dram_req_mask,
    input  logic                            dram_res_valid,
    input  logic [DRAM_ID_WIDTH-1:0]        dram_res_id,
    input  logic [BUS_BITS-1:0]             dram_res_rdata,
    output logic                            sram_wr_valid,
    input  logic                            sram_wr_ready,
    output logic [SCPAD_ADDR_WIDTH-1:0]     sram_wr_addr,
    output logic [NUM_COLS*ELEM_BITS-1:0]   sram_wr_data,
    output logic [NUM_COLS-1:0]             sram_wr_mask,
    output logic [SIDW-1:0]                 sram_wr_scpad_id,
    output logic                            done,
    output logic                            err
);

    localparam int BEATS     = NUM_COLS / EPB;
    localparam int ROW_BITS  = NUM_COLS * ELEM_BITS;
    localparam int ROW_BYTES = ROW_BITS / 8;
    localparam int BUS_BYTES = BUS_BITS / 8;
    localparam int BW        = $clog2(BEATS + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FLUSH} state_t;

    state_t                       state;
    logic [BW-1:0]                nb_q;
    logic [BW-1:0]                beat_cnt;
    logic [DIMW-1:0]              row_cnt;
    logic [DIMW-1:0]              num_rows_q;
    logic [DIMW-1:0]              num_cols_q;
    logic [DRAM_ADDR_WIDTH-1:0]   stride_q;
    logic [DRAM_ADDR_WIDTH-1:0]   row_base_q;
    logic [DRAM_ADDR_WIDTH-1:0]   beat_addr_q;
    logic [SCPAD_ADDR_WIDTH-1:0]  spad_row_q;
    logic [SIDW-1:0]              scpad_id_q;
    logic [BEATS-1:0]             rcvd_q;
    logic [ROW_BITS-1:0]          row_buf_q;
    logic                         dram_vld_q;
    logic                         sram_vld_q;
    logic                         err_q;

    logic [BEATS-1:0]             id_hot;
    logic [BEATS-1:0]             need;
    logic [BEATS-1:0]             rcvd_nxt;
    logic [EPB-1:0]               beat_mask;
    logic [NUM_COLS-1:0]          col_mask;
    logic [ROW_BITS-1:0]          row_data;
    logic                         accept;
    logic                         all_rcvd;
    logic                         sram_hs;
    logic                         last_row;

    always_comb begin
        id_hot    = '0;
        need      = '0;
        beat_mask = '0;
        col_mask  = '0;
        row_data  = '0;
        for (int unsigned i = 0; i < BEATS; i++) begin
            id_hot[i] = (32'(dram_res_id) == i);
            need[i]   = (i < 32'(nb_q));
        end
        for (int unsigned k = 0; k < EPB; k++)
            beat_mask[k] = (32'(beat_cnt) * EPB + k <= 32'(num_cols_q));
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
            col_mask[c] = (c <= 32'(num_cols_q));
            if (col_mask[c])
                row_data[c*ELEM_BITS +: ELEM_BITS] = row_buf_q[c*ELEM_BITS +: ELEM_BITS];
        end
    end

    // Beats are only accepted while a row is being fetched; anything else is an error.
    assign accept   = dram_res_valid && (state == ISSUE || state == WAIT) &&
                      (32'(dram_res_id) < 32'(nb_q)) && ((id_hot & rcvd_q) == '0);
    assign rcvd_nxt = accept ? (rcvd_q | id_hot) : rcvd_q;
    assign all_rcvd = ((rcvd_nxt & need) == need);
    assign sram_hs  = sram_vld_q && sram_wr_ready;
    assign last_row = (row_cnt == num_rows_q);

    assign req_ready        = (state == IDLE);
    assign dram_req_valid   = dram_vld_q;
    assign dram_req_addr    = beat_addr_q;
    assign dram_req_id      = dram_vld_q ? DRAM_ID_WIDTH'(beat_cnt) : '0;
    assign dram_req_mask    = dram_vld_q ? beat_mask : '0;
    assign sram_wr_valid    = sram_vld_q;
    assign sram_wr_addr     = spad_row_q;
    assign sram_wr_data     = row_data;
    assign sram_wr_mask     = sram_vld_q ? col_mask : '0;
    assign sram_wr_scpad_id = scpad_id_q;
    assign done             = sram_hs && last_row;
    assign err              = err_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            nb_q        <= '0;
            beat_cnt    <= '0;
            row_cnt     <= '0;
            num_rows_q  <= '0;
            num_cols_q  <= '0;
            stride_q    <= '0;
            row_base_q  <= '0;
            beat_addr_q <= '0;
            spad_row_q  <= '0;
            scpad_id_q  <= '0;
            rcvd_q      <= '0;
            row_buf_q   <= '0;
            dram_vld_q  <= 1'b0;
            sram_vld_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (dram_res_valid && !accept)
                err_q <= 1'b1;

            if (sram_hs) begin
                rcvd_q    <= '0;
                row_buf_q <= '0;
            end else begin
                rcvd_q <= rcvd_nxt;
                for (int unsigned i = 0; i < BEATS; i++)
                    if (accept && id_hot[i])
                        row_buf_q[i*BUS_BITS +: BUS_BITS] <= dram_res_rdata;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        num_rows_q  <= req_num_rows;
                        num_cols_q  <= req_num_cols;
                        stride_q    <= req_dram_stride;
                        scpad_id_q  <= req_scpad_id;
                        nb_q        <= BW'(req_num_cols / DIMW'(EPB)) + BW'(1);
                        beat_cnt    <= '0;
                        row_cnt     <= '0;
                        row_base_q  <= req_dram_addr;
                        beat_addr_q <= req_dram_addr;
                        spad_row_q  <= req_spad_addr;
                        dram_vld_q  <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (dram_req_ready) begin
                        beat_addr_q <= beat_addr_q + DRAM_ADDR_WIDTH'(BUS_BYTES);
                        beat_cnt    <= beat_cnt + BW'(1);
                        if (beat_cnt == nb_q - BW'(1)) begin
                            dram_vld_q <= 1'b0;
                            state      <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (all_rcvd) begin
                        sram_vld_q <= 1'b1;
                        state      <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (sram_wr_ready) begin
                        sram_vld_q <= 1'b0;
                        if (last_row) begin
                            state <= IDLE;
                        end else begin
                            row_cnt     <= row_cnt + DIMW'(1);
                            beat_cnt    <= '0;
                            row_base_q  <= row_base_q + stride_q;
                            beat_addr_q <= row_base_q + stride_q;
                            spad_row_q  <= spad_row_q + SCPAD_ADDR_WIDTH'(ROW_BYTES);
                            dram_vld_q  <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scpad_be_tile_loader.sv
// Scoreboard bench for scpad_be_tile_loader: expected beats and row writes are queued
// from the descriptor and popped as the DUT issues requests and writes rows.
module tb_scpad_be_tile_loader;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          req_valid, req_ready;
    logic [15:0]   req_spad_addr;
    logic [31:0]   req_dram_addr, req_dram_stride;
    logic [4:0]    req_num_rows, req_num_cols;
    logic [0:0]    req_scpad_id;
    logic          dram_req_valid, dram_req_ready;
    logic [31:0]   dram_req_addr;
    logic [3:0]    dram_req_id;
    logic [3:0]    dram_req_mask;
    logic          dram_res_valid;
    logic [3:0]    dram_res_id;
    logic [63:0]   dram_res_rdata;
    logic          sram_wr_valid, sram_wr_ready;
    logic [15:0]   sram_wr_addr;
    logic [511:0]  sram_wr_data;
    logic [31:0]   sram_wr_mask;
    logic [0:0]    sram_wr_scpad_id;
    logic          done, err;

    typedef struct packed { logic [31:0] addr; logic [3:0] id; logic [3:0] mask; } beat_t;
    typedef struct packed { logic [15:0] addr; logic [511:0] data; logic [31:0] mask; logic [0:0] sid; logic last; } wr_t;
    typedef struct packed { logic [3:0] id; logic [63:0] data; } rsp_t;

    beat_t       exp_beats[$];
    wr_t         exp_wr[$];
    rsp_t        inj_q[$];
    logic [3:0]  pend[$];
    int n_cmp = 0, n_err = 0, n_writes = 0, n_dones = 0;

    always #5 CLK = ~CLK;

    scpad_be_tile_loader #(
        .NUM_COLS(32), .ELEM_BITS(16), .BUS_BITS(64), .DRAM_ADDR_WIDTH(32),
        .DRAM_ID_WIDTH(4), .SCPAD_ADDR_WIDTH(16), .NUM_SCPADS(2)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_spad_addr(req_spad_addr), .req_dram_addr(req_dram_addr),
        .req_dram_stride(req_dram_stride), .req_num_rows(req_num_rows),
        .req_num_cols(req_num_cols), .req_scpad_id(req_scpad_id),
        .dram_req_valid(dram_req_valid), .dram_req_ready(dram_req_ready),
        .dram_req_addr(dram_req_addr), .dram_req_id(dram_req_id), .dram_req_mask(dram_req_mask),
        .dram_res_valid(dram_res_valid), .dram_res_id(dram_res_id), .dram_res_rdata(dram_res_rdata),
        .sram_wr_valid(sram_wr_valid), .sram_wr_ready(sram_wr_ready),
        .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data), .sram_wr_mask(sram_wr_mask),
        .sram_wr_scpad_id(sram_wr_scpad_id), .done(done), .err(err)
    );

    function automatic logic [15:0] elem_val(input logic [5:0] seed, input int row, input int e);
        return {seed, 4'(row), 6'(e)};
    endfunction

    function automatic logic [63:0] beat_data(input logic [5:0] seed, input int row, input int b);
        logic [63:0] d;
        for (int k = 0; k < 4; k++) d[k*16 +: 16] = elem_val(seed, row, b*4 + k);
        return d;
    endfunction

    task automatic run_tile(input logic [31:0] daddr, input logic [31:0] stride, input logic [15:0] saddr,
                            input int nrows, input int ncols, input logic [0:0] sid, input bit ooo,
                            input bit tog, input int stall, input bit inject, input logic [5:0] seed);
        int nb, cyc, row_issued, sent, stall_cnt, tile_writes;
        bit got_done, injected;
        beat_t eb;
        wr_t ew;
        rsp_t rs;
        logic [3:0] id;
        int perm[8];
        perm = '{7, 0, 3, 5, 1, 6, 2, 4};
        nb = ncols / 4 + 1;
        cyc = 0; row_issued = 0; sent = 0; stall_cnt = 0; tile_writes = 0;
        got_done = 0; injected = 0;
        pend.delete();
        inj_q.delete();

        @(posedge CLK); #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL req_ready_idle: got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_dram_addr = daddr; req_dram_stride = stride; req_spad_addr = saddr;
        req_num_rows = 5'(nrows); req_num_cols = 5'(ncols); req_scpad_id = sid;
        for (int r = 0; r <= nrows; r++) begin
            for (int b = 0; b < nb; b++) begin
                eb.addr = daddr + 32'(r) * stride + 32'(b * 8);
                eb.id   = 4'(b);
                for (int k = 0; k < 4; k++) eb.mask[k] = (b*4 + k <= ncols);
                exp_beats.push_back(eb);
            end
            for (int c = 0; c < 32; c++) begin
                ew.data[c*16 +: 16] = (c <= ncols) ? elem_val(seed, r, c) : 16'h0;
                ew.mask[c] = (c <= ncols);
            end
            ew.addr = saddr + 16'(r * 64);
            ew.sid  = sid;
            ew.last = (r == nrows);
            exp_wr.push_back(ew);
        end
        @(posedge CLK); #1;
        req_valid = 1'b0;

        while (!got_done && cyc < 3000) begin
            dram_req_ready = tog ? cyc[0] : 1'b1;
            dram_res_valid = 1'b0; dram_res_id = '0; dram_res_rdata = '0;
            if (inj_q.size() > 0) begin
                rs = inj_q.pop_front();
                dram_res_valid = 1'b1; dram_res_id = rs.id; dram_res_rdata = rs.data;
            end else if (!ooo && pend.size() > 0) begin
                id = pend.pop_front();
                dram_res_valid = 1'b1; dram_res_id = id; dram_res_rdata = beat_data(seed, tile_writes, int'(id));
                if (inject && !injected && id == 4'd2) begin
                    injected = 1;
                    inj_q.push_back('{id: 4'd2, data: 64'hDEAD_BEEF_CAFE_F00D});
                    inj_q.push_back('{id: 4'd9, data: 64'h0BAD_0BAD_0BAD_0BAD});
                end
            end else if (ooo && row_issued == nb && sent < nb) begin
                id = 4'(perm[sent]);
                sent++;
                dram_res_valid = 1'b1; dram_res_id = id; dram_res_rdata = beat_data(seed, tile_writes, int'(id));
            end
            sram_wr_ready = sram_wr_valid && (stall_cnt >= stall);
            #1;
            if (dram_req_valid) begin
                if (exp_beats.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL dram_req_unexpected: addr %h id %h", dram_req_addr, dram_req_id);
                end else begin
                    eb = exp_beats[0];
                    n_cmp++;
                    if (dram_req_addr !== eb.addr || dram_req_id !== eb.id || dram_req_mask !== eb.mask) begin
                        n_err++;
                        $display("FAIL dram_req: got addr %h id %h mask %h want addr %h id %h mask %h",
                                 dram_req_addr, dram_req_id, dram_req_mask, eb.addr, eb.id, eb.mask);
                    end
                    if (dram_req_ready) begin
                        eb = exp_beats.pop_front();
                        pend.push_back(dram_req_id);
                        row_issued++;
                    end
                end
            end
            if (sram_wr_valid) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL sram_wr_unexpected: addr %h", sram_wr_addr);
                end else begin
                    ew = exp_wr[0];
                    n_cmp++;
                    if (sram_wr_addr !== ew.addr || sram_wr_data !== ew.data ||
                        sram_wr_mask !== ew.mask || sram_wr_scpad_id !== ew.sid) begin
                        n_err++;
                        $display("FAIL sram_wr: got addr %h mask %h sid %h data %h want addr %h mask %h sid %h data %h",
                                 sram_wr_addr, sram_wr_mask, sram_wr_scpad_id, sram_wr_data,
                                 ew.addr, ew.mask, ew.sid, ew.data);
                    end
                    if (sram_wr_ready) begin
                        n_cmp++;
                        if (done !== ew.last) begin
                            n_err++; $display("FAIL done_on_write: got %b want %b", done, ew.last);
                        end
                        ew = exp_wr.pop_front();
                        if (done === 1'b1) n_dones++;
                        n_writes++; tile_writes++;
                        row_issued = 0; sent = 0; stall_cnt = 0;
                        if (ew.last) got_done = 1;
                    end else begin
                        stall_cnt++;
                    end
                end
            end else begin
                n_cmp++;
                if (done !== 1'b0) begin
                    n_err++; $display("FAIL done_spurious: got %b want 0", done);
                end
            end
            @(posedge CLK); #1;
            cyc++;
        end
        dram_req_ready = 1'b0; sram_wr_ready = 1'b0; dram_res_valid = 1'b0;
        if (!got_done) begin
            n_cmp++; n_err++; $display("FAIL tile_timeout: cycles %0d limit 3000", cyc);
        end
        n_cmp++;
        if (exp_beats.size() != 0 || exp_wr.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: beats left %0d writes left %0d want 0 0", exp_beats.size(), exp_wr.size());
        end
        exp_beats.delete();
        exp_wr.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if (req_ready !== 1'b1 || dram_req_valid !== 1'b0 || sram_wr_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got rdy %b dv %b sv %b done %b err %b want 1 0 0 0 0",
                     req_ready, dram_req_valid, sram_wr_valid, done, err);
        end
        n_cmp++;
        if (dram_req_addr !== '0 || dram_req_id !== '0 || dram_req_mask !== '0 ||
            sram_wr_addr !== '0 || sram_wr_data !== '0 || sram_wr_mask !== '0 || sram_wr_scpad_id !== '0) begin
            n_err++;
            $display("FAIL reset_data: got daddr %h mask %h saddr %h smask %h want all 0",
                     dram_req_addr, dram_req_mask, sram_wr_addr, sram_wr_mask);
        end
        nRST = 1'b1;
    endtask

    task automatic test_full_tile();
        int w0 = n_writes, d0 = n_dones;
        run_tile(32'h1000, 32'h100, 16'h0040, 0, 31, 1'b0, 0, 0, 0, 0, 6'h01);
        n_cmp++;
        if (n_writes - w0 != 1 || n_dones - d0 != 1) begin
            n_err++; $display("FAIL full_tile_counts: writes %0d dones %0d want 1 1", n_writes - w0, n_dones - d0);
        end
    endtask

    task automatic test_partial_row();
        int w0 = n_writes;
        run_tile(32'h3000, 32'h80, 16'h0100, 0, 9, 1'b1, 0, 0, 0, 0, 6'h02);
        n_cmp++;
        if (n_writes - w0 != 1) begin
            n_err++; $display("FAIL partial_writes: got %0d want 1", n_writes - w0);
        end
    endtask

    task automatic test_stride_wrap();
        int w0 = n_writes, d0 = n_dones;
        run_tile(32'h1000, 32'h200, 16'hFFC0, 2, 31, 1'b1, 0, 0, 0, 0, 6'h03);
        n_cmp++;
        if (n_writes - w0 != 3 || n_dones - d0 != 1) begin
            n_err++; $display("FAIL stride_counts: writes %0d dones %0d want 3 1", n_writes - w0, n_dones - d0);
        end
    endtask

    task automatic test_ooo_backpressure();
        int w0 = n_writes;
        run_tile(32'h4000, 32'h40, 16'h0200, 0, 31, 1'b0, 1, 1, 5, 0, 6'h04);
        n_cmp++;
        if (n_writes - w0 != 1) begin
            n_err++; $display("FAIL ooo_single_write: got %0d want 1", n_writes - w0);
        end
    endtask

    task automatic test_errors();
        n_cmp++;
        if (err !== 1'b0) begin
            n_err++; $display("FAIL err_before: got %b want 0", err);
        end
        run_tile(32'h5000, 32'h40, 16'h0300, 0, 31, 1'b1, 0, 0, 0, 1, 6'h05);
        n_cmp++;
        if (err !== 1'b1) begin
            n_err++; $display("FAIL err_set: got %b want 1", err);
        end
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if (err !== 1'b1) begin
            n_err++; $display("FAIL err_sticky: got %b want 1", err);
        end
    endtask

    task automatic test_reset_mid_tile();
        int issued = 0, cyc = 0;
        @(posedge CLK); #1;
        req_valid = 1'b1; req_dram_addr = 32'h2000; req_dram_stride = 32'h100; req_spad_addr = 16'h0080;
        req_num_rows = 5'd0; req_num_cols = 5'd15; req_scpad_id = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        dram_req_ready = 1'b1;
        while (issued < 4 && cyc < 50) begin
            if (dram_req_valid) issued++;
            @(posedge CLK); #1;
            cyc++;
        end
        dram_req_ready = 1'b0;
        n_cmp++;
        if (issued != 4 || dram_req_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_err++; $display("FAIL mid_tile_wait: issued %0d dv %b rdy %b want 4 0 0", issued, dram_req_valid, req_ready);
        end
        nRST = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1 || dram_req_valid !== 1'b0 || sram_wr_valid !== 1'b0 || err !== 1'b0 ||
            dram_req_addr !== '0 || dram_req_mask !== '0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL mid_tile_reset: rdy %b dv %b sv %b err %b daddr %h want 1 0 0 0 0",
                     req_ready, dram_req_valid, sram_wr_valid, err, dram_req_addr);
        end
        dram_res_valid = 1'b1; dram_res_id = 4'd1; dram_res_rdata = 64'h1111_2222_3333_4444;
        @(posedge CLK); #1;
        dram_res_valid = 1'b0;
        n_cmp++;
        if (err !== 1'b0) begin
            n_err++; $display("FAIL err_in_reset: got %b want 0", err);
        end
        nRST = 1'b1;
        @(posedge CLK); #1;
        n_cmp++;
        if (err !== 1'b0) begin
            n_err++; $display("FAIL err_after_release: got %b want 0", err);
        end
        dram_res_valid = 1'b1; dram_res_id = 4'd0; dram_res_rdata = 64'h5555_6666_7777_8888;
        @(posedge CLK); #1;
        dram_res_valid = 1'b0;
        n_cmp++;
        if (err !== 1'b1) begin
            n_err++; $display("FAIL err_late_response: got %b want 1", err);
        end
    endtask

    task automatic test_back_to_back();
        int w0 = n_writes, d0 = n_dones;
        run_tile(32'h6000, 32'h300, 16'h0400, 1, 23, 1'b1, 0, 0, 2, 0, 6'h06);
        run_tile(32'h7008, 32'h10, 16'h0500, 0, 3, 1'b0, 0, 1, 0, 0, 6'h07);
        n_cmp++;
        if (n_writes - w0 != 3 || n_dones - d0 != 2) begin
            n_err++; $display("FAIL back_to_back_counts: writes %0d dones %0d want 3 2", n_writes - w0, n_dones - d0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation limit reached");
        $fatal(1, "global timeout");
    end

    initial begin
        req_valid = 1'b0; req_spad_addr = '0; req_dram_addr = '0; req_dram_stride = '0;
        req_num_rows = '0; req_num_cols = '0; req_scpad_id = '0;
        dram_req_ready = 1'b0; dram_res_valid = 1'b0; dram_res_id = '0; dram_res_rdata = '0;
        sram_wr_ready = 1'b0;
        test_reset();
        test_full_tile();
        test_partial_row();
        test_stride_wrap();
        test_ooo_backpressure();
        test_errors();
        test_reset_mid_tile();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
